// File: rtl/processor_pkg.sv
// Shared register-file constants and writeback selection encoding.
// Imported by the writeback unit and its load-result FIFO.
package processor_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int NUM_REG = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_DRAIN,
        WB_ALU,
        WB_LOAD
    } wb_sel_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Load-result buffer in front of the register file write port.
// Power-of-two depth, pointers wrap naturally.
module wb_result_fifo
    import processor_pkg::*;
#(
    parameter int WIDTH = ADDR_W + DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-port arbiter with per-register pending scoreboard.
// ALU results go direct; load results queue in a small FIFO.
module reg_writeback_unit
    import processor_pkg::*;
#(
    parameter int DATA_W  = processor_pkg::DATA_W,
    parameter int ADDR_W  = processor_pkg::ADDR_W,
    parameter int NUM_REG = processor_pkg::NUM_REG,
    parameter int QDEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] query_rs1,
    input  logic [ADDR_W-1:0] query_rs2,
    output logic              busy_rs1,
    output logic              busy_rs2,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writedata,
    output logic              err_unexpected
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } result_t;

    logic [NUM_REG-1:0] pending;
    logic [NUM_REG-1:0] pending_nxt;
    logic               err_nxt;

    result_t            fifo_in;
    result_t            fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               fifo_pop;
    logic               mem_push;

    wb_sel_e            sel;
    logic               win_valid;
    logic               win_write;
    logic [ADDR_W-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;
    logic               issue_fire;

    assign issue_ready = (issue_rd == RZ) || !pending[issue_rd];
    assign issue_fire  = issue_valid && issue_ready;

    assign busy_rs1 = (query_rs1 != RZ) && pending[query_rs1];
    assign busy_rs2 = (query_rs2 != RZ) && pending[query_rs2];

    assign alu_ready = !fifo_full;
    assign mem_ready = !fifo_full;
    assign mem_push  = mem_valid && mem_ready;

    assign fifo_in.rd   = mem_rd;
    assign fifo_in.data = mem_data;

    wb_result_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (mem_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A full queue wins over the ALU so loads can never starve forever.
    always_comb begin
        sel = WB_NONE;
        priority case (1'b1)
            fifo_full && !fifo_empty: sel = WB_DRAIN;
            alu_valid:                sel = WB_ALU;
            fifo_count != '0:         sel = WB_LOAD;
            default:                  sel = WB_NONE;
        endcase
    end

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        fifo_pop = 1'b0;
        unique case (sel)
            WB_ALU: begin
                win_rd   = alu_rd;
                win_data = alu_data;
            end
            WB_DRAIN, WB_LOAD: begin
                win_rd   = fifo_head.rd;
                win_data = fifo_head.data;
                fifo_pop = 1'b1;
            end
            default: ;
        endcase
    end

    assign win_valid = (sel != WB_NONE);
    assign win_write = win_valid && (win_rd != RZ);

    always_comb begin
        pending_nxt = pending;
        if (issue_fire && issue_rd != RZ) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        if (win_write) begin
            pending_nxt[win_rd] = 1'b0;
        end
        err_nxt = err_unexpected || (win_write && !pending[win_rd]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending        <= '0;
            err_unexpected <= 1'b0;
            rf_write       <= 1'b0;
            rf_rd          <= '0;
            rf_writedata   <= '0;
        end else begin
            pending        <= pending_nxt;
            err_unexpected <= err_nxt;
            rf_write       <= win_write;
            if (win_write) begin
                rf_rd        <= win_rd;
                rf_writedata <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: vector table plus
// hand-written FIFO-fill and mid-drain reset sequences.
module tb_reg_writeback_unit;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        issue_ready;
    logic [3:0]  query_rs1;
    logic [3:0]  query_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        rf_write;
    logic [3:0]  rf_rd;
    logic [15:0] rf_writedata;
    logic        err_unexpected;

    int checks;
    int failures;

    reg_writeback_unit dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_ready    (issue_ready),
        .query_rs1      (query_rs1),
        .query_rs2      (query_rs2),
        .busy_rs1       (busy_rs1),
        .busy_rs2       (busy_rs2),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .rf_write       (rf_write),
        .rf_rd          (rf_rd),
        .rf_writedata   (rf_writedata),
        .err_unexpected (err_unexpected)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [3:0]  ird;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] md;
        logic [3:0]  q;
        logic        e_irdy;
        logic        e_busy;
        logic        e_wr;
        logic [3:0]  e_rd;
        logic [15:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic iv, input logic [3:0] ird,
        input logic av, input logic [3:0] ard, input logic [15:0] ad,
        input logic mv, input logic [3:0] mrd, input logic [15:0] md,
        input logic [3:0] q,
        input logic e_irdy, input logic e_busy, input logic e_wr,
        input logic [3:0] e_rd, input logic [15:0] e_data,
        input logic e_err);
        vec_t v;
        v.iv = iv; v.ird = ird;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.q = q;
        v.e_irdy = e_irdy; v.e_busy = e_busy; v.e_wr = e_wr;
        v.e_rd = e_rd; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = 4'd0;
        alu_valid   = 1'b0;
        alu_rd      = 4'd0;
        alu_data    = 16'd0;
        mem_valid   = 1'b0;
        mem_rd      = 4'd0;
        mem_data    = 16'd0;
        query_rs1   = 4'd0;
        query_rs2   = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic issue_one(input logic [3:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        @(posedge clock);
        #1;
        @(negedge clock);
        issue_valid = 1'b0;
        issue_rd    = 4'd0;
    endtask

    int  alu_acc, ld_acc, alu_wr, ld_wr, full_cyc, low_cnt;
    bit  seen_full, a_ok, m_ok;

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_rf_write", rf_write, 0);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_data", rf_writedata, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_mem_ready", mem_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        vecs[0]  = mk(1,3, 0,0,16'h0,    0,0,16'h0,    3, 1,0, 0,0,16'h0,    0);
        vecs[1]  = mk(0,3, 1,3,16'h1234, 0,0,16'h0,    3, 0,1, 1,3,16'h1234, 0);
        vecs[2]  = mk(0,3, 0,0,16'h0,    0,0,16'h0,    3, 1,0, 0,3,16'h1234, 0);
        vecs[3]  = mk(1,5, 0,0,16'h0,    0,0,16'h0,    5, 1,0, 0,3,16'h1234, 0);
        vecs[4]  = mk(1,5, 0,0,16'h0,    0,0,16'h0,    5, 0,1, 0,3,16'h1234, 0);
        vecs[5]  = mk(1,5, 1,5,16'h0055, 0,0,16'h0,    5, 0,1, 1,5,16'h0055, 0);
        vecs[6]  = mk(1,5, 0,0,16'h0,    0,0,16'h0,    5, 1,0, 0,5,16'h0055, 0);
        vecs[7]  = mk(0,5, 1,5,16'h00aa, 0,0,16'h0,    5, 0,1, 1,5,16'h00aa, 0);
        vecs[8]  = mk(0,0, 1,0,16'hffff, 0,0,16'h0,    0, 1,0, 0,5,16'h00aa, 0);
        vecs[9]  = mk(0,0, 0,0,16'h0,    1,7,16'h0777, 7, 1,0, 0,5,16'h00aa, 0);
        vecs[10] = mk(0,0, 0,0,16'h0,    0,0,16'h0,    7, 1,0, 1,7,16'h0777, 1);
        vecs[11] = mk(0,0, 0,0,16'h0,    0,0,16'h0,    7, 1,0, 0,7,16'h0777, 1);

        for (int i = 0; i < 12; i++) begin
            issue_valid = vecs[i].iv;
            issue_rd    = vecs[i].ird;
            alu_valid   = vecs[i].av;
            alu_rd      = vecs[i].ard;
            alu_data    = vecs[i].ad;
            mem_valid   = vecs[i].mv;
            mem_rd      = vecs[i].mrd;
            mem_data    = vecs[i].md;
            query_rs1   = vecs[i].q;
            query_rs2   = vecs[i].q;
            #1;
            check($sformatf("v%0d_issue_ready", i), issue_ready, vecs[i].e_irdy);
            check($sformatf("v%0d_busy1", i), busy_rs1, vecs[i].e_busy);
            check($sformatf("v%0d_busy2", i), busy_rs2, vecs[i].e_busy);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_rf_write", i), rf_write, vecs[i].e_wr);
            check($sformatf("v%0d_rf_rd", i), rf_rd, vecs[i].e_rd);
            check($sformatf("v%0d_rf_data", i), rf_writedata, vecs[i].e_data);
            check($sformatf("v%0d_err", i), err_unexpected, vecs[i].e_err);
            @(negedge clock);
        end
        idle();

        // FIFO fill under continuous ALU traffic
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            issue_one(4'(k));
        end
        alu_acc = 0; ld_acc = 0; alu_wr = 0; ld_wr = 0;
        full_cyc = -10; seen_full = 0; low_cnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            alu_valid = (alu_acc < 8);
            alu_rd    = 4'd8;
            alu_data  = 16'ha000 + 16'(alu_acc);
            mem_valid = (ld_acc < 5);
            mem_rd    = 4'(ld_acc + 1);
            mem_data  = 16'hb000 + 16'(ld_acc + 1);
            #1;
            a_ok = alu_ready;
            m_ok = mem_ready;
            if (!a_ok) low_cnt++;
            if (!m_ok && !seen_full) begin
                seen_full = 1;
                full_cyc  = cyc;
                check("fill_full_alu_ready", a_ok, 0);
            end
            if (cyc == full_cyc + 1) begin
                check("fill_after_alu_ready", a_ok, 1);
                check("fill_after_mem_ready", m_ok, 1);
            end
            @(posedge clock);
            #1;
            if (alu_valid && a_ok) alu_acc++;
            if (mem_valid && m_ok) ld_acc++;
            if (rf_write) begin
                if (rf_rd == 4'd8) begin
                    check("fill_alu_data", rf_writedata,
                          16'ha000 + 16'(alu_wr));
                    alu_wr++;
                end else begin
                    check("fill_load_rd", rf_rd, 4'(ld_wr + 1));
                    check("fill_load_data", rf_writedata,
                          16'hb000 + 16'(ld_wr + 1));
                    ld_wr++;
                end
            end
            @(negedge clock);
            if (alu_wr == 8 && ld_wr == 5) break;
        end
        idle();
        check("fill_seen_full", seen_full, 1);
        check("fill_full_cycle", full_cyc, 4);
        check("fill_alu_low_cycles", low_cnt, 2);
        check("fill_alu_writes", alu_wr, 8);
        check("fill_load_writes", ld_wr, 5);

        // Reset in the middle of a drain
        do_reset();
        issue_one(4'd2);
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1;
            alu_rd    = 4'd9;
            alu_data  = 16'h0900 + 16'(k);
            mem_valid = 1'b1;
            mem_rd    = 4'(10 + k);
            mem_data  = 16'hc000 + 16'(k);
            @(posedge clock);
            #1;
            @(negedge clock);
        end
        idle();
        query_rs2 = 4'd2;
        #2;
        check("drain_pre_busy2", busy_rs2, 1);
        check("drain_pre_rf_write", rf_write, 1);
        reset = 1'b0;
        #1;
        check("drain_rst_rf_write", rf_write, 0);
        check("drain_rst_busy2", busy_rs2, 0);
        check("drain_rst_mem_ready", mem_ready, 1);
        check("drain_rst_err", err_unexpected, 0);
        check("drain_rst_rf_rd", rf_rd, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("drain_stale_%0d", k), rf_write, 0);
        end
        check("drain_post_busy2", busy_rs2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Writer side of the 16x16-bit register file: collects results from the ALU and load unit and drives the file's single write port (write/rd/writedata).
- Keeps a per-register pending scoreboard so decode can stall on RAW/WAW hazards.
- Load results are buffered in a small FIFO. ALU results take a direct path with priority.
- Sits between execute/memory stages and reg_file_component.

Parameters:
- DATA_W, 16, result/register data width
- ADDR_W, 4, register index width
- NUM_REG, 16, number of architectural registers (r0 hardwired zero)
- QDEPTH, 4, load-result FIFO depth (power of two, >=2)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- issue_valid  in  1  decode issues an instruction writing issue_rd
- issue_rd  in  ADDR_W  destination of issued instruction
- issue_ready  out  1  combinational; 0 when issue_rd (nonzero) is already pending
- query_rs1  in  ADDR_W  decode source 1 index
- query_rs2  in  ADDR_W  decode source 2 index
- busy_rs1  out  1  combinational; pending[query_rs1], always 0 for index 0
- busy_rs2  out  1  combinational; pending[query_rs2], always 0 for index 0
- alu_valid  in  1  ALU result valid
- alu_rd  in  ADDR_W  ALU result destination
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  combinational; 0 only when FIFO full
- mem_valid  in  1  load result valid
- mem_rd  in  ADDR_W  load destination
- mem_data  in  DATA_W  load data
- mem_ready  out  1  combinational; !fifo_full
- rf_write  out  1  registered write strobe to register file
- rf_rd  out  ADDR_W  registered write index
- rf_writedata  out  DATA_W  registered write data
- err_unexpected  out  1  sticky; a nonzero-rd result arrived for a non-pending register

Behaviour:
- Reset (reset=0, async): pending[] = 0, FIFO empty (rd/wr pointers and count = 0), rf_write=0, rf_rd=0, rf_writedata=0, err_unexpected=0. Reset mid-operation discards buffered results and in-flight write.
- Handshake: transfer occurs on a rising edge when valid && ready. Producers hold valid/rd/data stable until accepted.
- Issue: accept if issue_valid && issue_ready. Sets pending[issue_rd] at that edge. issue_rd=0 always ready, sets nothing.
- Load path: accepted mem result pushed into FIFO {rd,data}. Pointers wrap modulo QDEPTH. count ranges 0..QDEPTH.
- Write-port arbitration each cycle, highest priority first:
  - FIFO full and non-empty: pop FIFO head; alu_ready=0.
  - alu_valid: write ALU result.
  - FIFO non-empty: pop head.
  - Otherwise no write.
- Push and pop in the same cycle are allowed; count is unchanged.
- When full: mem_ready=0 and alu_ready=0. This cycle drains the head. Next cycle count=QDEPTH-1 and both ready again.
- Latency: the chosen result appears on rf_write/rf_rd/rf_writedata the edge after acceptance (ALU) or pop (FIFO). Exactly one cycle. rf_write=0 on idle cycles; rf_rd/rf_writedata hold last values.
- Results with rd=0: accepted (or popped) normally, rf_write stays 0, no scoreboard effect.
- Scoreboard clear: pending[rd] clears at the edge where the result is selected for writing, i.e. the same edge rf_write is registered high.
- Clear and issue of the same rd in one cycle cannot occur, because issue_ready is computed from current state. If issue sets rd X while a clear targets rd Y, both take effect.
- err_unexpected sets when a nonzero-rd result is selected while pending[rd]=0. It is cleared only by reset. The write is still performed.
- Widths: no arithmetic on data; count is ADDR of clog2(QDEPTH)+1 bits.

Decomposition:
- Shared package (processor_pkg): DATA_W, ADDR_W, NUM_REG constants; REG_ZERO=0 constant.
- One sub-module, wb_result_fifo (QDEPTH x (ADDR_W+DATA_W), push/pop/full/empty/count, same clock/reset).
- Arbitration and scoreboard live in the top.

Test Plan:
- Reset then issue rd=3, ALU result rd=3 data=0x1234 → next cycle rf_write=1, rf_rd=3, rf_writedata=0x1234; busy on query 3 is 1 before and 0 after.
- Issue rd=5 twice back-to-back → second cycle issue_ready=0 until the rd=5 result is written, then issue_ready=1.
- Continuous alu_valid plus 5 load results rd=1..5 (QDEPTH=4) → FIFO fills, mem_ready=0 at count 4, alu_ready drops for 1 cycle while head (rd=1) drains. Loads are written in order 1..5 and no ALU result is lost.
- ALU result rd=0 data=0xFFFF → accepted, rf_write stays 0, err_unexpected stays 0.
- Load result rd=7 with pending[7]=0 → rf_write=1 rd=7, err_unexpected=1 and it stays set.
- Assert reset low mid-drain with FIFO count=3 and pending[2]=1 → immediately rf_write=0, busy for 2 is 0, mem_ready=1. After release, no stale writes appear.
